bist_ctrl: RTL and testbench
============================

BIST_CTRL -- requirements
Module: bist_ctrl

Interface
REQ-001 Parameter NUM_PATTERNS, default 15: patterns applied per run; legal range 1..15.
REQ-002 Parameter LFSR_SEED, default 4'b0001: first pattern of each run; must be nonzero.
REQ-003 Parameter GOLDEN_SIG, default 4'h0: expected final signature.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  run request, sampled on clk.
REQ-007 abort  input  1  cancels a run in progress, sampled on clk.
REQ-008 sig_in  input  4  signature from the downstream 4-bit MISR output.
REQ-009 pattern  output  4  test pattern driven to the circuit under test feeding the MISR.
REQ-010 misr_n_rst  output  1  active-low clear to the MISR.
REQ-011 busy  output  1  high in CLEAR, RUN and COMPARE.
REQ-012 done  output  1  high in DONE; result valid.
REQ-013 pass  output  1  high in DONE when the captured signature equals GOLDEN_SIG.
REQ-014 sig_captured  output  4  final signature captured in COMPARE.

Function
REQ-015 States: IDLE, CLEAR, RUN, COMPARE, DONE; every output driven directly from a flop; no combinational outputs.
REQ-016 IDLE: start=1 and abort=0 -> CLEAR; otherwise stay.
REQ-017 CLEAR, 1 cycle: misr_n_rst=0; LFSR loaded with LFSR_SEED; pattern counter cleared to 0; -> RUN.
REQ-018 RUN: pattern equals the LFSR value; each cycle the LFSR advances as next = {q[2:0], q[3]^q[0]} and the counter increments.
REQ-019 RUN lasts exactly NUM_PATTERNS cycles, then -> COMPARE.
REQ-020 LFSR sequence from 4'b0001: 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8, then repeats with period 15.
REQ-021 COMPARE, 1 cycle: sig_captured <= sig_in; pass <= (sig_in == GOLDEN_SIG); -> DONE.
REQ-022 DONE: done=1; pass and sig_captured held.
REQ-023 DONE with start=1 and abort=0 -> CLEAR; done, pass and sig_captured clear on entry to CLEAR.
REQ-024 pattern=4'h0 in every state except RUN.
REQ-025 misr_n_rst=0 in IDLE and CLEAR; misr_n_rst=1 in RUN, COMPARE and DONE.
REQ-026 start in CLEAR, RUN or COMPARE is ignored.
REQ-027 abort=1 in CLEAR, RUN, COMPARE or DONE -> IDLE next cycle; done, pass and sig_captured cleared.
REQ-028 start and abort high together: abort wins.
REQ-029 Latency: start sampled at edge T -> done first high after edge T+NUM_PATTERNS+2.
REQ-030 The counter width covers NUM_PATTERNS without wrap; the LFSR never reaches 4'h0.

Reset
REQ-031 rst=1 asynchronously forces IDLE, LFSR=LFSR_SEED, counter=0, pattern=0, misr_n_rst=0, busy=0, done=0, pass=0, sig_captured=0.
REQ-032 rst asserted mid-run aborts the run immediately; no result is retained.
REQ-033 After rst deasserts, the block stays in IDLE until start is sampled high.

Verification
REQ-034 Bench wires pattern directly to a 4-bit MISR input; NUM_PATTERNS=3; GOLDEN_SIG=4'h5; start pulse -> patterns 1,3,7 on three consecutive cycles; sig_captured=4'h5; pass=1; done high 5 cycles after the start edge.
REQ-035 Same setup with GOLDEN_SIG=4'h4 -> done=1, pass=0, sig_captured=4'h5.
REQ-036 NUM_PATTERNS=15 -> 15 RUN cycles with pattern sequence exactly as in REQ-020; counter and LFSR checked for no wrap to 0.
REQ-037 abort at RUN cycle 2 -> IDLE next cycle; busy=0, done=0, pattern=0, misr_n_rst=0; a following start reruns and reproduces sig_captured=4'h5.
REQ-038 start held high in RUN, then start and abort pulsed together in IDLE -> no extra run and no state change; start from DONE restarts with done cleared in CLEAR.
REQ-039 rst pulsed mid-RUN, asynchronous to clk -> all outputs take their REQ-031 values before the next clk edge.

Source files
------------

// File: rtl/bist_ctrl.sv
// BIST sequencer: clears the MISR, drives an LFSR pattern burst,
// then captures and judges the final signature.
module bist_ctrl #(
  parameter int          NUM_PATTERNS = 15,
  parameter logic [3:0]  LFSR_SEED    = 4'b0001,
  parameter logic [3:0]  GOLDEN_SIG   = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] sig_in,
  output logic [3:0] pattern,
  output logic       misr_n_rst,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] sig_captured
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, RUN, COMPARE, DONE
  } state_t;

  state_t        state;
  logic [3:0]    lfsr;
  logic [CW-1:0] cnt;
  logic          go;

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[0]};
  endfunction

  assign go = start && !abort &&
              (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      cnt          <= '0;
      pattern      <= 4'h0;
      misr_n_rst   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      sig_captured <= 4'h0;
    end else if (abort && state != IDLE) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      cnt          <= '0;
      pattern      <= 4'h0;
      misr_n_rst   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      sig_captured <= 4'h0;
    end else if (go) begin
      state        <= CLEAR;
      lfsr         <= LFSR_SEED;
      cnt          <= '0;
      pattern      <= 4'h0;
      misr_n_rst   <= 1'b0;
      busy         <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      sig_captured <= 4'h0;
    end else begin
      case (state)
        CLEAR: begin
          // pattern flop tracks the LFSR throughout RUN
          state      <= RUN;
          pattern    <= lfsr;
          misr_n_rst <= 1'b1;
        end
        RUN: begin
          if (cnt == LAST) begin
            state   <= COMPARE;
            pattern <= 4'h0;
          end else begin
            cnt     <= cnt + 1'b1;
            lfsr    <= lfsr_next(lfsr);
            pattern <= lfsr_next(lfsr);
          end
        end
        COMPARE: begin
          state        <= DONE;
          sig_captured <= sig_in;
          pass         <= (sig_in == GOLDEN_SIG);
          busy         <= 1'b0;
          done         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_ctrl.sv
// Bench for bist_ctrl: three configurations fed by rotate-xor MISRs,
// directed vector table, corner sequences and a random run vs. a model.
module tb_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;

  logic [3:0] pat [3];
  logic [3:0] sig [3];
  logic [3:0] misr [3];
  logic       nr [3];
  logic       bsy [3];
  logic       dn [3];
  logic       ps [3];

  always #5 clk = ~clk;

  bist_ctrl #(.NUM_PATTERNS(3), .GOLDEN_SIG(4'h5)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sig_in(misr[0]), .pattern(pat[0]), .misr_n_rst(nr[0]),
    .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
    .sig_captured(sig[0]));

  bist_ctrl #(.NUM_PATTERNS(3), .GOLDEN_SIG(4'h4)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sig_in(misr[1]), .pattern(pat[1]), .misr_n_rst(nr[1]),
    .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
    .sig_captured(sig[1]));

  bist_ctrl #(.NUM_PATTERNS(15)) u2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sig_in(misr[2]), .pattern(pat[2]), .misr_n_rst(nr[2]),
    .busy(bsy[2]), .done(dn[2]), .pass(ps[2]),
    .sig_captured(sig[2]));

  // downstream MISR: rotate left, xor in the pattern
  for (genvar g = 0; g < 3; g++) begin : g_misr
    always_ff @(posedge clk)
      if (!nr[g]) misr[g] <= 4'h0;
      else misr[g] <= {misr[g][2:0], misr[g][3]} ^ pat[g];
  end

  // reference: position in the run, -1 idle, 0 clear, 1..N run,
  // N+1 compare, N+2 done
  logic [3:0] seq [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4,
                           4'h8};
  int         np [3]   = '{3, 3, 15};
  logic [3:0] gold [3] = '{4'h5, 4'h4, 4'h0};
  logic [3:0] esig [3];
  int         pos [3];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       s;
    logic       a;
    logic [3:0] pat;
    logic       nr;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] sig;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic s, a, input logic [3:0] p,
                              input logic n, b, d, q,
                              input logic [3:0] sg);
    return '{s, a, p, n, b, d, q, sg};
  endfunction

  task automatic cmp(input string nm, input int i,
                     input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] t=%0t got=%h want=%h",
               nm, i, $time, act, exp);
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      logic       run, d;
      logic [3:0] ep;
      run = pos[i] >= 1 && pos[i] <= np[i];
      d   = pos[i] == np[i] + 2;
      ep  = run ? seq[pos[i] - 1] : 4'h0;
      cmp("pattern", i, pat[i], ep);
      cmp("misr_n_rst", i, {3'b0, nr[i]}, {3'b0, pos[i] >= 1});
      cmp("busy", i, {3'b0, bsy[i]},
          {3'b0, pos[i] >= 0 && pos[i] <= np[i] + 1});
      cmp("done", i, {3'b0, dn[i]}, {3'b0, d});
      cmp("pass", i, {3'b0, ps[i]},
          {3'b0, d && esig[i] == gold[i]});
      cmp("sig_captured", i, sig[i], d ? esig[i] : 4'h0);
    end
  endtask

  task automatic model_edge(input logic s, input logic a);
    for (int i = 0; i < 3; i++) begin
      if (pos[i] >= 0 && a) pos[i] = -1;
      else if ((pos[i] == -1 || pos[i] == np[i] + 2) && s && !a)
        pos[i] = 0;
      else if (pos[i] >= 0 && pos[i] < np[i] + 2) pos[i]++;
    end
  endtask

  task automatic step(input logic s, input logic a);
    start = s;
    abort = a;
    @(posedge clk);
    model_edge(s, a);
    #1;
    model_check();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] m;
      pos[i] = -1;
      m = 4'h0;
      for (int k = 0; k < np[i]; k++) m = {m[2:0], m[3]} ^ seq[k];
      esig[i] = m;
    end

    tbl[0]  = mk('0, '0, 4'h0, '0, '0, '0, '0, 4'h0);
    tbl[1]  = mk('1, '0, 4'h0, '0, '1, '0, '0, 4'h0);
    tbl[2]  = mk('1, '0, 4'h1, '1, '1, '0, '0, 4'h0);
    tbl[3]  = mk('0, '0, 4'h3, '1, '1, '0, '0, 4'h0);
    tbl[4]  = mk('0, '0, 4'h7, '1, '1, '0, '0, 4'h0);
    tbl[5]  = mk('0, '0, 4'h0, '1, '1, '0, '0, 4'h0);
    tbl[6]  = mk('0, '0, 4'h0, '1, '0, '1, '1, 4'h5);
    tbl[7]  = mk('0, '0, 4'h0, '1, '0, '1, '1, 4'h5);
    tbl[8]  = mk('1, '0, 4'h0, '0, '1, '0, '0, 4'h0);
    tbl[9]  = mk('0, '1, 4'h0, '0, '0, '0, '0, 4'h0);
    tbl[10] = mk('1, '0, 4'h0, '0, '1, '0, '0, 4'h0);
    tbl[11] = mk('0, '0, 4'h1, '1, '1, '0, '0, 4'h0);
    tbl[12] = mk('0, '0, 4'h3, '1, '1, '0, '0, 4'h0);
    tbl[13] = mk('0, '1, 4'h0, '0, '0, '0, '0, 4'h0);
    tbl[14] = mk('1, '1, 4'h0, '0, '0, '0, '0, 4'h0);
    tbl[15] = mk('1, '0, 4'h0, '0, '1, '0, '0, 4'h0);
    tbl[16] = mk('0, '0, 4'h1, '1, '1, '0, '0, 4'h0);
    tbl[17] = mk('0, '0, 4'h3, '1, '1, '0, '0, 4'h0);
    tbl[18] = mk('0, '0, 4'h7, '1, '1, '0, '0, 4'h0);
    tbl[19] = mk('0, '0, 4'h0, '1, '1, '0, '0, 4'h0);
    tbl[20] = mk('0, '0, 4'h0, '1, '0, '1, '1, 4'h5);
    tbl[21] = mk('0, '1, 4'h0, '0, '0, '0, '0, 4'h0);

    #2;
    model_check();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_check();

    for (int r = 0; r < 22; r++) begin
      step(tbl[r].s, tbl[r].a);
      cmp("vec_pattern", r, pat[0], tbl[r].pat);
      cmp("vec_nrst", r, {3'b0, nr[0]}, {3'b0, tbl[r].nr});
      cmp("vec_busy", r, {3'b0, bsy[0]}, {3'b0, tbl[r].busy});
      cmp("vec_done", r, {3'b0, dn[0]}, {3'b0, tbl[r].done});
      cmp("vec_pass", r, {3'b0, ps[0]}, {3'b0, tbl[r].pass});
      cmp("vec_sig", r, sig[0], tbl[r].sig);
    end

    // full 15-pattern run on u2, then a DONE restart
    step(1'b1, 1'b0);
    for (int k = 0; k < 17; k++) step(1'b0, 1'b0);
    cmp("long_done", 2, {3'b0, dn[2]}, 4'h1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // asynchronous reset in the middle of a run
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) pos[i] = -1;
    #1;
    model_check();
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
